// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: hold, advance by one instruction, or take a
// word-aligned redirect target.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  pc_sel_e           pc_sel,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:      pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      // Low bits are dropped so the fetch address is always word aligned.
      PC_REDIRECT: pc_d = redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect support.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a pending request keeps its
  // address until accepted unless a redirect replaces it.

  fetch_state_e      state_q, state_d;
  logic              discard_q, discard_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  pc_sel_e           pc_sel;
  logic [ADDR_W-1:0] pc;
  logic              misalign;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    pc_sel        = PC_HOLD;
    case (state_q)
      REQ: begin
        if (misalign) begin
          state_d = HALT;
        end else if (redirect_valid) begin
          pc_sel = PC_REDIRECT;
          // A request accepted alongside the redirect carries the old PC.
          if (imem_req_ready) begin
            discard_d = 1'b1;
            state_d   = WAIT;
          end
        end else if (imem_req_ready) begin
          discard_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (misalign) begin
          state_d = HALT;
        end else if (redirect_valid) begin
          pc_sel = PC_REDIRECT;
          if (imem_resp_valid) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            instr_d       = imem_resp_data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          if (misalign) begin
            state_d = HALT;
          end else begin
            pc_sel  = PC_REDIRECT;
            state_d = REQ;
          end
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          pc_sel        = PC_INC;
          state_d       = REQ;
        end
      end
      HALT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= REQ;
      discard_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // HALT is terminal, so the fault stays set until reset.
  always_comb begin
    fault_d = fault_q | (state_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = (state_q == REQ) && !reset;
  assign imem_addr      = pc;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level fetch model, directed
// scenarios, randomized traffic, and a mid-run reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_fault     (fetch_fault)
  );

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;
  logic [31:0] acc_q[$];  // addresses of accepted requests
  logic [31:0] con_q[$];  // PCs of instructions handed to decode

  // Reference model of the fetch stage at transaction level.
  logic [31:0] m_pc;        // address the next request must carry
  bit          m_out;       // a request is in flight at the memory
  bit          m_stale;     // that in-flight request was overtaken by a redirect
  logic [31:0] m_out_addr;
  bit          m_present;   // an instruction is offered to decode
  logic [31:0] m_ipc;
  logic [31:0] m_idata;
  bit          m_halt;
  bit          m_fault;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_out = 0; m_stale = 0; m_out_addr = 32'h0;
    m_present = 0; m_ipc = 32'h0; m_idata = NOP; m_halt = 0; m_fault = 0;
  endtask

  task automatic drive_idle();
    redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = '0; instr_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic do_cycle(input bit rv, input logic [31:0] rpc, input bit rr, input bit sv,
                          input bit ir, input bit d_auto, input logic [31:0] d);
    bit exp_req, accepted, resp, consumed, bad;
    @(negedge clk);
    exp_req = !m_halt && !m_out && !m_present;
    check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_present));
    check("instr", instr, m_idata);
    check("instr_pc", instr_pc, m_ipc);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));

    resp = sv && m_out;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rr;
    imem_resp_valid = resp;
    imem_resp_data  = d_auto ? mem_word(m_out_addr) : d;
    instr_ready     = ir;
    vectors++;

    accepted = exp_req && rr;
    consumed = m_present && ir;
    if (accepted) acc_q.push_back(m_pc);
    if (consumed) con_q.push_back(m_ipc);
    bad = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    bad = rv && (rpc[1:0] != 2'b00);
`endif
    if (m_halt) begin
      m_present = 0;
    end else if (bad) begin
      m_halt = 1; m_fault = 1; m_present = 0; m_out = 0;
    end else if (rv) begin
      if (accepted) begin
        m_out = 1; m_stale = 1; m_out_addr = m_pc;
      end else if (m_out) begin
        if (resp) m_out = 0;
        else      m_stale = 1;
      end
      m_present = 0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (accepted) begin
        m_out = 1; m_stale = 0; m_out_addr = m_pc;
      end
      if (resp) begin
        m_out = 0;
        if (!m_stale) begin
          m_present = 1; m_ipc = m_out_addr; m_idata = mem_word(m_out_addr);
        end
      end
      if (consumed) begin
        m_present = 0;
        m_pc = m_ipc + 32'd4;
      end
    end
  endtask

  task automatic rand_cycle();
    logic [31:0] rpc;
    rpc = 32'($urandom_range(0, 2047)) << 2;
    if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
`ifndef FETCH_MISALIGN_CHECK_EN
    rpc[1:0] = 2'($urandom_range(0, 3));
`endif
    do_cycle($urandom_range(0, 11) == 0, rpc, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'b1, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n10;
    model_reset();
    apply_reset();

    // Streaming with everything ready.
    repeat (9) do_cycle(0, 0, 1, 1, 1, 1, 0);
    check("t1_acc_n", 32'(acc_q.size()), 32'd3);
    check("t1_acc0", acc_q[0], 32'h0);
    check("t1_acc1", acc_q[1], 32'h4);
    check("t1_acc2", acc_q[2], 32'h8);
    check("t1_con_n", 32'(con_q.size()), 32'd3);
    check("t1_con2", con_q[2], 32'h8);
    repeat (3) do_cycle(0, 0, 1, 1, 1, 1, 0);

    // Memory stalls at 0x10.
    repeat (3) begin
      do_cycle(0, 0, 0, 0, 1, 1, 0);
      check("t2_req", 32'(imem_req_valid), 32'h1);
      check("t2_addr", imem_addr, 32'h10);
    end
    do_cycle(0, 0, 1, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    n10 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 32'h10) n10++;
    check("t2_one_accept", 32'(n10), 32'd1);

    // Decode stalls in HOLD.
    repeat (5) begin
      do_cycle(0, 0, 0, 0, 0, 1, 0);
      check("t3_valid", 32'(instr_valid), 32'h1);
      check("t3_pc", instr_pc, 32'h10);
      check("t3_instr", instr, mem_word(32'h10));
      check("t3_noreq", 32'(imem_req_valid), 32'h0);
    end
    do_cycle(0, 0, 0, 0, 1, 1, 0);
    do_cycle(0, 0, 1, 0, 0, 1, 0);
    check("t3_next_addr", imem_addr, 32'h14);

    // Redirect while waiting; stale response must be dropped.
    do_cycle(1, 32'h100, 0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF);
    do_cycle(0, 0, 1, 0, 0, 1, 0);
    check("t4_addr", imem_addr, 32'h100);
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    check("t4_pc", instr_pc, 32'h100);
    check("t4_instr", instr, mem_word(32'h100));

    // Redirect coincident with decode handshake at 0x8.
    do_cycle(1, 32'h8, 0, 0, 0, 1, 0);
    do_cycle(0, 0, 1, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    do_cycle(1, 32'h40, 0, 0, 1, 1, 0);
    check("t5_pc", instr_pc, 32'h8);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    check("t5_addr", imem_addr, 32'h40);

    // PC wraps past the top of the address space.
    do_cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 0);
    do_cycle(0, 0, 1, 0, 0, 1, 0);
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 1, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    check("wrap_zero", imem_addr, 32'h0);

    // Redirect in the same cycle a request is accepted.
    do_cycle(1, 32'h200, 1, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 1, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    check("req_redir_addr", imem_addr, 32'h200);
    check("req_redir_nvalid", 32'(instr_valid), 32'h0);

`ifndef FETCH_MISALIGN_CHECK_EN
    do_cycle(1, 32'h102, 0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 1, 0);
    check("mask_addr", imem_addr, 32'h100);
`endif

    repeat (1500) rand_cycle();
    apply_reset();
    repeat (1500) rand_cycle();

`ifdef FETCH_MISALIGN_CHECK_EN
    do_cycle(1, 32'h102, 0, 0, 0, 1, 0);
    repeat (6) begin
      do_cycle(0, 0, 1, 1, 1, 1, 0);
      check("halt_fault", 32'(fetch_fault), 32'h1);
      check("halt_noreq", 32'(imem_req_valid), 32'h0);
    end
    apply_reset();
    do_cycle(0, 0, 0, 0, 0, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction control decoder. Holds the PC and issues word requests to instruction memory over a request/response handshake. Presents each fetched 32-bit instruction plus its PC to decode over a valid/ready handshake. Accepts PC redirects from execute for branches, JAL and JALR.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
ADDR_W, 32, width of the PC and memory address.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_addr  out  ADDR_W  fetch address; equals the current PC.
imem_resp_valid  in  1  response data valid; one response per accepted request, in order.
imem_resp_data  in  32  fetched instruction word.
instr_valid  out  1  instruction available to decode.
instr_ready  in  1  decode consumes the instruction this cycle.
instr  out  32  instruction word, registered.
instr_pc  out  ADDR_W  PC of the presented instruction, registered.
redirect_valid  in  1  PC redirect request from execute.
redirect_pc  in  ADDR_W  redirect target.
fetch_fault  out  1  misaligned-target fault; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state=REQ, pc=RESET_PC, discard=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, imem_req_valid=0 during reset, fetch_fault=0.
- Outputs imem_req_valid and imem_addr are combinational from state and pc. All other outputs are registered.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid:
    - discard=0: latch instr=resp_data, instr_pc=pc, set instr_valid, go to HOLD.
    - discard=1: drop the data, clear discard, go to REQ.
  - HOLD: instr_valid=1, instr and instr_pc stable. On instr_ready: clear instr_valid, pc=pc+4, go to REQ.
- Best-case latency: request-accept cycle to instr_valid is 1 cycle after imem_resp_valid. There is no overlap; at most one request is outstanding.
- Redirect has the highest priority and is sampled every cycle:
  - REQ: pc=redirect_pc, stay in REQ. If imem_req_ready is high in the same cycle, the accepted request is marked discard=1 and the FSM goes to WAIT.
  - WAIT: pc=redirect_pc, discard=1. A response arriving in the same cycle is dropped and the FSM goes directly to REQ.
  - HOLD: clear instr_valid, pc=redirect_pc, go to REQ. If instr_ready is high in the same cycle, the handshake completes (decode took the word) and pc still takes redirect_pc, not pc+4.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- imem_addr must stay stable while imem_req_valid=1 and imem_req_ready=0, unless a redirect occurs.
- Reset mid-transaction: any outstanding response after reset release is not expected. Memory must be reset together with this block.

Optional Feature:
FETCH_MISALIGN_CHECK_EN
- Defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault (sticky until reset), goes to the terminal state HALT, and issues no further requests. instr_valid is held at 0 in HALT.
- Undefined: fetch_fault is tied to 0, redirect_pc[1:0] is forced to 2'b00, and HALT does not exist.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (REQ, WAIT, HOLD, HALT);
  - INSTR_BYTES=4;
  - NOP_INSTR=32'h0000_0013;
  - the default RESET_PC.
- Natural sub-module: fetch_pc_reg, which owns the PC register with next-PC select (hold / +4 / redirect), its async reset, and alignment masking.

Test Plan:
- Reset release, memory always ready with 1-cycle response, decode always ready -> addresses 0x0, 0x4, 0x8 issued; instr_pc matches each; each instruction is presented once.
- imem_req_ready low for 3 cycles at pc=0x10 -> imem_addr holds 0x10 with req_valid=1 all 3 cycles; exactly one request is accepted.
- instr_ready low for 5 cycles in HOLD -> instr and instr_pc stable, no new request; on ready, next request is addr=pc+4.
- Redirect to 0x100 in WAIT; stale response 0xDEADBEEF arrives 2 cycles later -> data dropped; next request at 0x100; instr_pc=0x100 for the next instruction.
- Redirect to 0x40 coincident with instr_ready in HOLD at pc=0x8 -> next request at 0x40, not 0xC.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> fetch_fault=1 the next cycle, no further imem_req_valid, fault stays high until reset.
